// File: rtl/jk_pkg.sv
// Shared defaults and J/K command encoding for the JK up/down counter.
package jk_pkg;

    localparam int WIDTH_DEF   = 4;
    localparam int MODULUS_DEF = 10;

    // J/K command, encoded as {J, K}.
    typedef enum logic [1:0] {
        HOLD   = 2'b00,
        RESET  = 2'b01,
        SET    = 2'b10,
        TOGGLE = 2'b11
    } jk_cmd_e;

endpackage : jk_pkg

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-low reset and complementary outputs.
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qb
);

    logic r_q;

    // Next state comes only from the J/K command; reset forces 0 immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            r_q <= 1'b0;
        end else begin
            case (jk_cmd_e'({j, k}))
                HOLD:    r_q <= r_q;
                RESET:   r_q <= 1'b0;
                SET:     r_q <= 1'b1;
                TOGGLE:  r_q <= ~r_q;
                default: r_q <= r_q;
            endcase
        end
    end

    assign q  = r_q;
    assign qb = ~r_q;

endmodule : jk_cell

// File: rtl/jk_updown_counter.sv
// Modulo up/down counter built from JK cells: J/K steering, terminal count and a
// sticky wrap flag. Priority per edge is load > en > hold.
module jk_updown_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int MODULUS = MODULUS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             clr_wrap,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_qb;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic [WIDTH-1:0] w_load_val;
    logic             w_tc;
    logic             w_wrap_j;
    logic             w_wrap_k;
    logic             r_wrap;

    // Out-of-range load values saturate to the top of the count range.
    assign w_load_val = (int'(d) >= MODULUS) ? Q_MAX : d;

    // Terminal count: the next enabled edge in the current direction will wrap.
    assign w_tc = en & ~load & ((up & (w_q == Q_MAX)) | (~up & (w_q == '0)));

    // J/K steering: load, wrap, ripple-style toggle chain, or hold.
    always_comb begin
        logic v_chain;
        // NOTE: every output gets a default first so no path can infer a latch.
        w_j     = '0;
        w_k     = '0;
        v_chain = 1'b1;
        if (load) begin
            w_j = w_load_val;
            w_k = ~w_load_val;
        end else if (en) begin
            if (up && (w_q == Q_MAX)) begin
                w_j = '0;
                w_k = '1;
            end else if (!up && (w_q == '0)) begin
                w_j = Q_MAX;
                w_k = ~Q_MAX;
            end else begin
                // Bit i toggles when all lower bits are 1 (up) or all 0 (down).
                for (int i = 0; i < WIDTH; i++) begin
                    w_j[i]  = v_chain;
                    w_k[i]  = v_chain;
                    v_chain = v_chain & (up ? w_q[i] : ~w_q[i]);
                end
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        jk_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .j     (w_j[g]),
            .k     (w_k[g]),
            .q     (w_q[g]),
            .qb    (w_qb[g])
        );
    end

    // Wrap flag in J/K form: a wrap sets it and wins over a simultaneous clear.
    assign w_wrap_j = w_tc;
    assign w_wrap_k = clr_wrap & ~w_tc;

    // Sticky wrap flag, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrap <= 1'b0;
        end else begin
            case (jk_cmd_e'({w_wrap_j, w_wrap_k}))
                HOLD:    r_wrap <= r_wrap;
                RESET:   r_wrap <= 1'b0;
                SET:     r_wrap <= 1'b1;
                TOGGLE:  r_wrap <= ~r_wrap;
                default: r_wrap <= r_wrap;
            endcase
        end
    end

    assign q    = w_q;
    assign qb   = w_qb;
    assign tc   = w_tc;
    assign wrap = r_wrap;

endmodule : jk_updown_counter

// File: tb/tb_jk_updown_counter.sv
// Directed self-checking bench for jk_updown_counter (WIDTH=4, MODULUS=10).
module tb_jk_updown_counter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] d;
    logic       clr_wrap;
    logic [3:0] q;
    logic [3:0] qb;
    logic       tc;
    logic       wrap;

    int n_pass;
    int n_total;

    jk_updown_counter #(
        .WIDTH   (4),
        .MODULUS (10)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .load     (load),
        .d        (d),
        .clr_wrap (clr_wrap),
        .q        (q),
        .qb       (qb),
        .tc       (tc),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges; the next rising edge is the first live one.
    task automatic apply_reset();
        step();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; d = 4'd0; clr_wrap = 1'b0;
        #3;
        n_total++; if (q !== 4'd0) $display("FAIL reset_q: got %0d want 0", q); else n_pass++;
        n_total++; if (qb !== 4'hF) $display("FAIL reset_qb: got %h want f", qb); else n_pass++;
        n_total++; if (wrap !== 1'b0) $display("FAIL reset_wrap: got %b want 0", wrap); else n_pass++;
        n_total++; if (tc !== 1'b0) $display("FAIL reset_tc_idle: got %b want 0", tc); else n_pass++;
        en = 1'b1; up = 1'b0;
        #1;
        n_total++; if (tc !== 1'b1) $display("FAIL reset_tc_down: got %b want 1", tc); else n_pass++;
        step();
        n_total++; if (q !== 4'd0) $display("FAIL reset_hold_q: got %0d want 0", q); else n_pass++;
        en = 1'b0; up = 1'b1;
    endtask

    task automatic test_up_count();
        logic [3:0] exp_q;
        en = 1'b1; up = 1'b1; load = 1'b0; clr_wrap = 1'b0;
        apply_reset();
        n_total++; if (tc !== 1'b0) $display("FAIL up_tc_start: got %b want 0", tc); else n_pass++;
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_q = 4'(k % 10);
            n_total++; if (q !== exp_q) $display("FAIL up_q[%0d]: got %0d want %0d", k, q, exp_q); else n_pass++;
            n_total++; if (qb !== ~exp_q) $display("FAIL up_qb[%0d]: got %h want %h", k, qb, ~exp_q); else n_pass++;
            n_total++; if (wrap !== (k >= 10)) $display("FAIL up_wrap[%0d]: got %b want %b", k, wrap, (k >= 10)); else n_pass++;
            n_total++; if (tc !== (exp_q == 4'd9)) $display("FAIL up_tc[%0d]: got %b want %b", k, tc, (exp_q == 4'd9)); else n_pass++;
        end
        en = 1'b0;
    endtask

    task automatic test_down_wrap();
        logic [3:0] exp_seq [3] = '{4'd9, 4'd8, 4'd7};
        en = 1'b1; up = 1'b0; load = 1'b0; clr_wrap = 1'b0;
        apply_reset();
        n_total++; if (tc !== 1'b1) $display("FAIL down_tc_at0: got %b want 1", tc); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            step();
            n_total++; if (q !== exp_seq[k]) $display("FAIL down_q[%0d]: got %0d want %0d", k, q, exp_seq[k]); else n_pass++;
            n_total++; if (wrap !== 1'b1) $display("FAIL down_wrap[%0d]: got %b want 1", k, wrap); else n_pass++;
            n_total++; if (tc !== 1'b0) $display("FAIL down_tc[%0d]: got %b want 0", k, tc); else n_pass++;
        end
        en = 1'b0;
    endtask

    task automatic test_load();
        en = 1'b0; up = 1'b1; load = 1'b0; clr_wrap = 1'b0;
        apply_reset();
        load = 1'b1; en = 1'b1; d = 4'd7;
        #1;
        n_total++; if (tc !== 1'b0) $display("FAIL load_tc_masked: got %b want 0", tc); else n_pass++;
        step();
        n_total++; if (q !== 4'd7) $display("FAIL load_q7: got %0d want 7", q); else n_pass++;
        n_total++; if (wrap !== 1'b0) $display("FAIL load_wrap7: got %b want 0", wrap); else n_pass++;
        d = 4'd13;
        step();
        n_total++; if (q !== 4'd9) $display("FAIL load_sat: got %0d want 9", q); else n_pass++;
        n_total++; if (wrap !== 1'b0) $display("FAIL load_wrap_sat: got %b want 0", wrap); else n_pass++;
        d = 4'd3;
        step();
        n_total++; if (q !== 4'd3) $display("FAIL load_at_tc_q: got %0d want 3", q); else n_pass++;
        n_total++; if (wrap !== 1'b0) $display("FAIL load_at_tc_wrap: got %b want 0", wrap); else n_pass++;
        load = 1'b0; en = 1'b0;
        step();
        n_total++; if (q !== 4'd3) $display("FAIL hold_q: got %0d want 3", q); else n_pass++;
    endtask

    task automatic test_clr_wrap();
        load = 1'b1; en = 1'b0; d = 4'd9; clr_wrap = 1'b0;
        step();
        load = 1'b0; en = 1'b1; up = 1'b1; clr_wrap = 1'b1;
        step();
        n_total++; if (q !== 4'd0) $display("FAIL clr_same_edge_q: got %0d want 0", q); else n_pass++;
        n_total++; if (wrap !== 1'b1) $display("FAIL clr_same_edge_wrap: got %b want 1", wrap); else n_pass++;
        en = 1'b0;
        step();
        n_total++; if (wrap !== 1'b0) $display("FAIL clr_wrap: got %b want 0", wrap); else n_pass++;
        n_total++; if (q !== 4'd0) $display("FAIL clr_hold_q: got %0d want 0", q); else n_pass++;
        clr_wrap = 1'b0;
    endtask

    task automatic test_async_reset();
        load = 1'b1; en = 1'b0; d = 4'd9; clr_wrap = 1'b0;
        step();
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int k = 0; k < 6; k++) step();
        n_total++; if (q !== 4'd5) $display("FAIL async_pre_q: got %0d want 5", q); else n_pass++;
        n_total++; if (wrap !== 1'b1) $display("FAIL async_pre_wrap: got %b want 1", wrap); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++; if (q !== 4'd0) $display("FAIL async_q: got %0d want 0", q); else n_pass++;
        n_total++; if (qb !== 4'hF) $display("FAIL async_qb: got %h want f", qb); else n_pass++;
        n_total++; if (wrap !== 1'b0) $display("FAIL async_wrap: got %b want 0", wrap); else n_pass++;
        #1;
        rst_n = 1'b1;
        step();
        n_total++; if (q !== 4'd1) $display("FAIL async_first_count: got %0d want 1", q); else n_pass++;
        en = 1'b0;
    endtask

    task automatic test_direction_change();
        logic [3:0] exp_seq [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd3, 4'd2, 4'd1, 4'd2};
        en = 1'b1; up = 1'b1; load = 1'b0; clr_wrap = 1'b0;
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            step();
            n_total++; if (q !== exp_seq[k]) $display("FAIL dir_q[%0d]: got %0d want %0d", k, q, exp_seq[k]); else n_pass++;
            n_total++; if (qb !== ~exp_seq[k]) $display("FAIL dir_qb[%0d]: got %h want %h", k, qb, ~exp_seq[k]); else n_pass++;
            up = (k >= 3 && k < 6) ? 1'b0 : 1'b1;
        end
        en = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_up_count();
        test_down_wrap();
        test_load();
        test_clr_wrap();
        test_async_reset();
        test_direction_change();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_jk_updown_counter

// File: doc/jk_updown_counter.md
JK_UPDOWN_COUNTER -- requirements
Module: jk_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter bit width (2..16).
REQ-002 Parameter MODULUS, default 10, count range 0..MODULUS-1 (2..2**WIDTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  count enable.
REQ-006 up  input  1  direction, 1 = increment, 0 = decrement.
REQ-007 load  input  1  synchronous parallel load request.
REQ-008 d  input  WIDTH  parallel load value.
REQ-009 clr_wrap  input  1  clears the sticky wrap flag.
REQ-010 q  output  WIDTH  current count.
REQ-011 qb  output  WIDTH  bitwise complement of q.
REQ-012 tc  output  1  terminal count, combinational.
REQ-013 wrap  output  1  sticky flag, set on any wrap-around.

Function
REQ-014 Every state bit SHALL be a JK flip-flop cell; each next-state update SHALL come only from that bit's J/K inputs.
REQ-015 Priority per edge SHALL be load > en > hold.
REQ-016 load=1: J[i]=d[i], K[i]=~d[i]; q=d one cycle later; d>=MODULUS SHALL load MODULUS-1.
REQ-017 en=1, up=1, q<MODULUS-1: bit i SHALL toggle (J=K=1) iff all lower bits are 1; q=q+1 after one edge.
REQ-018 en=1, up=0, q>0: bit i SHALL toggle iff all lower bits are 0; q=q-1 after one edge.
REQ-019 en=1, up=1, q=MODULUS-1: J=0, K=1 on all bits; q=0 next cycle.
REQ-020 en=1, up=0, q=0: J/K SHALL force q=MODULUS-1 next cycle.
REQ-021 en=0, load=0: J=K=0 on all bits; q holds.
REQ-022 tc SHALL be en & ~load & ((up & q==MODULUS-1) | (~up & q==0)).
REQ-023 wrap SHALL set on the edge where a REQ-019/REQ-020 wrap occurs.
REQ-024 wrap SHALL clear on an edge with clr_wrap=1 and no wrap; a simultaneous wrap and clr_wrap SHALL leave wrap=1.
REQ-025 A change of up mid-count SHALL take effect on the next edge with no lost or extra count.
REQ-026 load with en=1 SHALL NOT set wrap, even when q was at terminal count.
REQ-027 qb SHALL equal ~q at all times, including during reset.

Reset
REQ-028 rst_n=0 SHALL immediately force q=0, qb=all-ones and wrap=0, independent of clk.
REQ-029 While rst_n=0, tc SHALL follow REQ-022 with q=0.
REQ-030 Reset deassertion SHALL be taken synchronously; the first count occurs on the first rising edge with rst_n=1.
REQ-031 Reset asserted mid-count or mid-load SHALL abort the operation with no partial update.

Structure
REQ-032 Shared package jk_pkg SHALL hold the WIDTH/MODULUS defaults and the J/K command constants: HOLD=00, RESET=01, SET=10, TOGGLE=11.
REQ-033 One sub-module, jk_cell, SHALL implement a JK flip-flop with rst_n and outputs q and qb.
REQ-034 jk_updown_counter SHALL instantiate WIDTH copies of jk_cell and contain only the J/K steering logic, tc and wrap.

Verification (WIDTH=4, MODULUS=10)
REQ-035 Reset release, en=1, up=1 for 12 edges -> q: 1..9,0,1,2; wrap=1 from the 10th edge; tc=1 only while q=9.
REQ-036 q=0, en=1, up=0 -> q: 9,8,7; wrap=1 after the first edge; tc=1 only while q=0.
REQ-037 load=1, d=7, en=1 -> q=7; then load=1, d=13 -> q=9; wrap unchanged in both cases.
REQ-038 q=9, up=1, en=1 and clr_wrap=1 on the same edge -> q=0, wrap=1; next edge with clr_wrap=1 and no wrap -> wrap=0.
REQ-039 rst_n pulled low between edges while q=5 -> q=0, qb=4'hF and wrap=0 immediately, before the next clk edge.
REQ-040 Up count to 4, then up=0 for 3 edges, then up=1 -> q: 3,2,1,2; qb=~q checked on every cycle.
